// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: I/S/B/J/U/zimm/shamt formats, extended to XLEN,
// presented through a registered valid/ready output stage with an optional skid entry.
module imm_gen_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5,
    parameter int unsigned SKID  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [2:0]       immsrc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    localparam int unsigned FULL_W = 64;

    logic [FULL_W-1:0] sext;
    logic [FULL_W-1:0] dec_imm64;
    logic [XLEN-1:0]   dec_imm;
    logic              dec_err;
    logic              unused_bits;

    logic              main_valid;
    logic [XLEN-1:0]   main_imm;
    logic [TAG_W-1:0]  main_tag;
    logic              main_err;
    logic              skid_valid;
    logic [XLEN-1:0]   skid_imm;
    logic [TAG_W-1:0]  skid_tag;
    logic              skid_err;
    logic              in_ready_q;

    logic              accept;
    logic              drain;
    logic              main_valid_n;
    logic              skid_valid_n;
    logic              load_main;
    logic              main_from_skid;
    logic              load_skid;

    // Decode every format at 64 bits, then keep the low XLEN bits.
    always_comb begin
        sext      = {FULL_W{instr[31]}};
        dec_imm64 = '0;
        dec_err   = 1'b0;
        case (immsrc)
            3'b000: dec_imm64 = {sext[63:12], instr[31:20]};
            3'b001: dec_imm64 = {sext[63:12], instr[31:25], instr[11:7]};
            3'b010: dec_imm64 = {sext[63:12], instr[7], instr[30:25], instr[11:8], 1'b0};
            3'b011: dec_imm64 = {sext[63:20], instr[19:12], instr[20], instr[30:21], 1'b0};
            3'b100: dec_imm64 = {sext[63:32], instr[31:12], 12'b0};
            3'b101: dec_imm64 = {59'b0, instr[19:15]};
            3'b110: begin
                if (XLEN == 64) begin
                    dec_imm64 = {58'b0, instr[25:20]};
                end else begin
                    dec_imm64 = {59'b0, instr[24:20]};
                    dec_err   = instr[25];
                end
            end
            default: dec_err = 1'b1;
        endcase
    end

    assign dec_imm     = dec_imm64[XLEN-1:0];
    assign unused_bits = ^{instr[6:0], dec_imm64};

    // Occupancy update: flush wins, skid refills main before any new input.
    always_comb begin
        accept         = in_valid && in_ready;
        drain          = main_valid && out_ready;
        main_valid_n   = main_valid;
        skid_valid_n   = skid_valid;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            main_valid_n = 1'b0;
            skid_valid_n = 1'b0;
        end else if (!main_valid || drain) begin
            if (skid_valid) begin
                load_main      = 1'b1;
                main_from_skid = 1'b1;
                main_valid_n   = 1'b1;
                skid_valid_n   = 1'b0;
            end else if (accept) begin
                load_main    = 1'b1;
                main_valid_n = 1'b1;
            end else begin
                main_valid_n = 1'b0;
            end
        end else if (accept && (SKID != 0)) begin
            load_skid    = 1'b1;
            skid_valid_n = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            main_imm   <= '0;
            main_tag   <= '0;
            main_err   <= 1'b0;
            skid_valid <= 1'b0;
            skid_imm   <= '0;
            skid_tag   <= '0;
            skid_err   <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            main_valid <= main_valid_n;
            skid_valid <= skid_valid_n;
            in_ready_q <= !skid_valid_n;
            if (load_main) begin
                main_imm <= main_from_skid ? skid_imm : dec_imm;
                main_tag <= main_from_skid ? skid_tag : in_tag;
                main_err <= main_from_skid ? skid_err : dec_err;
            end
            if (load_skid) begin
                skid_imm <= dec_imm;
                skid_tag <= in_tag;
                skid_err <= dec_err;
            end
        end
    end

    assign in_ready  = (SKID != 0) ? in_ready_q : (!main_valid || out_ready);
    assign out_valid = main_valid;
    assign out_imm   = main_imm;
    assign out_tag   = main_tag;
    assign out_err   = main_err;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: XLEN=32/SKID=1 and XLEN=64/SKID=0 instances side by side.
module tb_imm_gen_pipe;

    localparam int unsigned TAG_W = 5;
    localparam int unsigned NVEC  = 12;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic [31:0]      instr;
    logic [2:0]       immsrc;
    logic [TAG_W-1:0] in_tag;

    logic             in_ready32, out_valid32, out_ready32, out_err32;
    logic [31:0]      out_imm32;
    logic [TAG_W-1:0] out_tag32;
    logic             in_ready64, out_valid64, out_ready64, out_err64;
    logic [63:0]      out_imm64;
    logic [TAG_W-1:0] out_tag64;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0]  sel;
        logic [31:0] ins;
        logic [31:0] imm32;
        logic        err32;
        logic [63:0] imm64;
        logic        err64;
    } vec_t;

    vec_t vec [NVEC];

    imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W), .SKID(1)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32),
        .instr(instr), .immsrc(immsrc), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready32),
        .out_imm(out_imm32), .out_tag(out_tag32), .out_err(out_err32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W), .SKID(0)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64),
        .instr(instr), .immsrc(immsrc), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready64),
        .out_imm(out_imm64), .out_tag(out_tag64), .out_err(out_err64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [2:0] sel, input logic [31:0] ins, input int tag);
        in_valid = 1'b1;
        immsrc   = sel;
        instr    = ins;
        in_tag   = TAG_W'(tag);
    endtask

    initial begin
        vec[0]  = '{3'b000, 32'hFFF00093, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b0};
        vec[1]  = '{3'b000, 32'h7FF00013, 32'h000007FF, 1'b0, 64'h00000000000007FF, 1'b0};
        vec[2]  = '{3'b001, 32'hFE112E23, 32'hFFFFFFFC, 1'b0, 64'hFFFFFFFFFFFFFFFC, 1'b0};
        vec[3]  = '{3'b010, 32'h00000463, 32'h00000008, 1'b0, 64'h0000000000000008, 1'b0};
        vec[4]  = '{3'b010, 32'hFE000EE3, 32'hFFFFFFFC, 1'b0, 64'hFFFFFFFFFFFFFFFC, 1'b0};
        vec[5]  = '{3'b011, 32'h0080006F, 32'h00000008, 1'b0, 64'h0000000000000008, 1'b0};
        vec[6]  = '{3'b011, 32'hFFDFF06F, 32'hFFFFFFFC, 1'b0, 64'hFFFFFFFFFFFFFFFC, 1'b0};
        vec[7]  = '{3'b100, 32'h123450B7, 32'h12345000, 1'b0, 64'h0000000012345000, 1'b0};
        vec[8]  = '{3'b100, 32'h800000B7, 32'h80000000, 1'b0, 64'hFFFFFFFF80000000, 1'b0};
        vec[9]  = '{3'b101, 32'h800F8073, 32'h0000001F, 1'b0, 64'h000000000000001F, 1'b0};
        vec[10] = '{3'b110, 32'h02501013, 32'h00000005, 1'b1, 64'h0000000000000025, 1'b0};
        vec[11] = '{3'b111, 32'hFFFFFFFF, 32'h00000000, 1'b1, 64'h0000000000000000, 1'b1};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
        instr = '0; immsrc = '0; in_tag = '0;
        out_ready32 = 1'b1; out_ready64 = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_valid32", 64'(out_valid32), 64'd0);
        check("rst_imm32",   64'(out_imm32),   64'd0);
        check("rst_tag32",   64'(out_tag32),   64'd0);
        check("rst_err32",   64'(out_err32),   64'd0);
        check("rst_ready32", 64'(in_ready32),  64'd1);
        check("rst_valid64", 64'(out_valid64), 64'd0);
        check("rst_ready64", 64'(in_ready64),  64'd1);
        rst_n = 1'b1;

        // Back-to-back decode table at full throughput
        for (int i = 0; i < int'(NVEC); i++) begin
            @(negedge clk);
            drive(vec[i].sel, vec[i].ins, i);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_valid32", i), 64'(out_valid32), 64'd1);
            check($sformatf("vec%0d_imm32", i),   64'(out_imm32),   64'(vec[i].imm32));
            check($sformatf("vec%0d_err32", i),   64'(out_err32),   64'(vec[i].err32));
            check($sformatf("vec%0d_tag32", i),   64'(out_tag32),   64'(i));
            check($sformatf("vec%0d_imm64", i),   out_imm64,        vec[i].imm64);
            check($sformatf("vec%0d_err64", i),   64'(out_err64),   64'(vec[i].err64));
            check($sformatf("vec%0d_ready32", i), 64'(in_ready32),  64'd1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("drain_valid32", 64'(out_valid32), 64'd0);

        // Skid fill under backpressure, then in-order drain
        @(negedge clk);
        out_ready32 = 1'b0; out_ready64 = 1'b0;
        drive(3'b000, 32'h00100093, 1);
        @(posedge clk);
        #1;
        check("skid_t1_ready32", 64'(in_ready32), 64'd1);
        check("skid_t1_tag32",   64'(out_tag32),  64'd1);
        @(negedge clk);
        drive(3'b000, 32'h00200093, 2);
        @(posedge clk);
        #1;
        check("skid_t2_ready32", 64'(in_ready32), 64'd0);
        check("skid_t2_tag32",   64'(out_tag32),  64'd1);
        check("skid_t2_imm32",   64'(out_imm32),  64'd1);
        check("skid_t2_ready64", 64'(in_ready64), 64'd0);
        check("skid_t2_tag64",   64'(out_tag64),  64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("skid_hold_valid32", 64'(out_valid32), 64'd1);
        check("skid_hold_tag32",   64'(out_tag32),   64'd1);
        out_ready32 = 1'b1; out_ready64 = 1'b1;
        @(posedge clk);
        #1;
        check("skid_pop_valid32", 64'(out_valid32), 64'd1);
        check("skid_pop_tag32",   64'(out_tag32),   64'd2);
        check("skid_pop_imm32",   64'(out_imm32),   64'd2);
        check("skid_pop_ready32", 64'(in_ready32),  64'd1);
        check("skid_pop_valid64", 64'(out_valid64), 64'd0);
        @(posedge clk);
        #1;
        check("skid_empty_valid32", 64'(out_valid32), 64'd0);
        check("skid_empty_tag32",   64'(out_tag32),   64'd2);

        // Flush with both entries held and an input presented
        @(negedge clk);
        out_ready32 = 1'b0;
        drive(3'b000, 32'h00300093, 3);
        @(negedge clk);
        drive(3'b000, 32'h00400093, 4);
        @(negedge clk);
        check("flush_pre_ready32", 64'(in_ready32), 64'd0);
        check("flush_pre_tag32",   64'(out_tag32),  64'd3);
        drive(3'b000, 32'h00500093, 5);
        flush = 1'b1;
        @(posedge clk);
        #1;
        check("flush_valid32", 64'(out_valid32), 64'd0);
        check("flush_ready32", 64'(in_ready32),  64'd1);
        check("flush_tag32",   64'(out_tag32),   64'd3);
        check("flush_valid64", 64'(out_valid64), 64'd0);
        check("flush_tag64",   64'(out_tag64),   64'd4);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; out_ready32 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("flush_after_valid32", 64'(out_valid32), 64'd0);
        check("flush_after_valid64", 64'(out_valid64), 64'd0);

        // Asynchronous reset mid-stream
        @(negedge clk);
        drive(3'b000, 32'h00600093, 6);
        @(posedge clk);
        #1;
        check("pre_rst_tag32", 64'(out_tag32), 64'd6);
        #2;
        rst_n = 1'b0;
        drive(3'b000, 32'h00700093, 7);
        #1;
        check("arst_valid32", 64'(out_valid32), 64'd0);
        check("arst_imm32",   64'(out_imm32),   64'd0);
        check("arst_tag32",   64'(out_tag32),   64'd0);
        check("arst_ready32", 64'(in_ready32),  64'd1);
        check("arst_valid64", 64'(out_valid64), 64'd0);
        check("arst_imm64",   out_imm64,        64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(3'b000, 32'h00800093, 8);
        @(posedge clk);
        #1;
        check("post_rst_valid32", 64'(out_valid32), 64'd1);
        check("post_rst_tag32",   64'(out_tag32),   64'd8);
        check("post_rst_imm32",   64'(out_imm32),   64'd8);
        check("post_rst_tag64",   64'(out_tag64),   64'd8);
        @(negedge clk);
        in_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
